mips_ula_arbiter: RTL and testbench
===================================

Name: mips_ula_arbiter

Overview:
Shares one MIPS_ULA instance between two requesters, req0 and req1, for example a main datapath port and a branch/compare unit. Each requester presents an opcode and operands through a valid/ready handshake. A round-robin arbiter picks one requester, registers its operands and runs the ALU for one cycle. The registered result is returned on a single tagged response channel with backpressure. The block sits between the issue logic and the ALU and makes the ALU a multi-cycle, arbitrated resource.

Parameters:
WSIZE, 32, datapath width passed to the ALU
STAT_W, 16, width of each saturating statistics counter (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_opcode  in  4  ALU opcode
req0_a  in  WSIZE  operand A
req0_b  in  WSIZE  operand B
req1_valid, req1_ready, req1_opcode, req1_a, req1_b  same as req0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts the response
rsp_id  out  1  index of the requester that owns the response
rsp_r  out  WSIZE  ALU result (forced to 0 on overflow)
rsp_z  out  1  ALU zero flag (1 on result==0 or on overflow)
rsp_o  out  1  ALU overflow flag
stat_grant0  out  STAT_W  grants to req0
stat_grant1  out  STAT_W  grants to req1
stat_ovf  out  STAT_W  responses with overflow

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - state=IDLE; rsp_valid=0; rsp_id=0; rsp_r=0; rsp_z=0; rsp_o=0.
  - req*_ready=0; last_grant=1, so req0 wins the first contention.
  - All operand registers 0; all stat counters 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The ready outputs are combinational in IDLE only: reqN_ready = grant_N.
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1. Neither -> stay in IDLE.
  - Both valid -> grant the index != last_grant.
  - On a grant: capture opcode/A/B and id, update last_grant, go to EXEC.
- EXEC:
  - The ALU is driven only from the captured registers.
  - At the clock edge, R/Z/O are registered into rsp_* and rsp_id is set; go to RESP.
- RESP:
  - rsp_valid=1. rsp_* are held stable until rsp_valid & rsp_ready.
  - On that handshake go to IDLE; rsp_valid drops the next cycle.
- Latency: accept in cycle N -> rsp_valid in cycle N+2. Minimum spacing between accepts is 3 cycles.
- A request is never accepted while a response is pending; both ready outputs are 0 in EXEC and RESP.
- Requesters must hold valid and payload until ready; a dropped valid before the grant is simply not served.
- Unknown opcode: passed through; the ALU yields R=0, Z=1, O=0.
- Reset mid-operation: the in-flight operation is discarded and no response is produced; outputs return to reset values immediately.
- Counters saturate at 2^STAT_W-1 (no wrap).
  - stat_grantN increments on each grant to N.
  - stat_ovf increments on each EXEC->RESP transition with O=1.

Optional Feature:
- Macro: MIPS_ULA_ARB_STATS_EN.
- Defined: the three stat counters are implemented as above.
- Undefined: stat_grant0, stat_grant1 and stat_ovf are tied to 0 and no counter flops exist. The ports remain present, so the interface is identical either way.

Decomposition:
- Package mips_ula_pkg holds:
  - opcode localparams ALU_AND=4'b0000, ALU_OR=0001, ALU_ADD=0010, ALU_ADDU=0011, ALU_SUB=0100, ALU_SUBU=0101, ALU_SLT=0110, ALU_SLTU=0111, ALU_NOR=1000, ALU_XOR=1001, ALU_SLL=1010, ALU_SRL=1011, ALU_SRA=1100, ALU_ROR=1101, ALU_ROL=1110.
  - the FSM state typedef {IDLE, EXEC, RESP}.
- Sub-module: a single instance of the existing MIPS_ULA (WSIZE passed through).
- The arbiter, FSM and counters stay in this module.

Test Plan:
- req0 only, ADD A=5, B=7, rsp_ready=1 -> req0_ready in cycle 0; rsp_valid in cycle 2 with id=0, R=12, Z=0, O=0; rsp_valid low in cycle 3.
- Both requesters continuously valid (req0 AND 0xF0F0/0x00FF, req1 SUB 3-3) -> grants alternate 0,1,0,1 starting with 0. Responses: id0 R=0x00F0, Z=0; id1 R=0, Z=1.
- req1 ADD A=0x7FFFFFFF, B=1 -> R=0, Z=1, O=1; stat_ovf=1 when MIPS_ULA_ARB_STATS_EN is defined, 0 otherwise.
- Backpressure: rsp_ready=0 for 5 cycles with req0 held valid -> rsp_* stable; both ready outputs stay 0; req0 is accepted 1 cycle after rsp_ready=1.
- rst asserted asynchronously during EXEC (SLTU A=1, B=2) -> rsp_valid=0 immediately and no response after reset. The first subsequent contention is granted to req0.
- Opcode 4'b1111 with A=3, B=4 -> R=0, Z=1, O=0; SRA A=4, B=0x80000000 -> R=0xF8000000.

Source files
------------

// File: rtl/mips_ula_pkg.sv
// Shared opcodes and FSM state type for the arbitrated MIPS ALU.
package mips_ula_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_ADDU = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_SUBU = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_NOR  = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1001;
   localparam logic [3:0] ALU_SLL  = 4'b1010;
   localparam logic [3:0] ALU_SRL  = 4'b1011;
   localparam logic [3:0] ALU_SRA  = 4'b1100;
   localparam logic [3:0] ALU_ROR  = 4'b1101;
   localparam logic [3:0] ALU_ROL  = 4'b1110;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } arb_state_t;

endpackage

// File: rtl/MIPS_ULA.sv
// Combinational MIPS ALU: shifts/rotates move operand b by a[log2(WSIZE)-1:0].
// Signed overflow on ADD/SUB forces the result to zero and raises both o and z.
module MIPS_ULA
   import mips_ula_pkg::*;
#(
   parameter int WSIZE = 32
) (
   input  logic [3:0]       opcode,
   input  logic [WSIZE-1:0] a,
   input  logic [WSIZE-1:0] b,
   output logic [WSIZE-1:0] r,
   output logic             z,
   output logic             o
);

   localparam int SH_W = $clog2(WSIZE);

   logic [SH_W-1:0]    sh;
   logic [WSIZE-1:0]   sum;
   logic [WSIZE-1:0]   diff;
   logic [WSIZE-1:0]   res;
   logic [2*WSIZE-1:0] ror_w;
   logic [2*WSIZE-1:0] rol_w;
   logic               add_ovf;
   logic               sub_ovf;
   logic               ovf;

   assign sh   = a[SH_W-1:0];
   assign sum  = a + b;
   assign diff = a - b;

   // Overflow iff the operand signs make it possible and the result sign flips.
   assign add_ovf = (a[WSIZE-1] == b[WSIZE-1]) && (sum[WSIZE-1]  != a[WSIZE-1]);
   assign sub_ovf = (a[WSIZE-1] != b[WSIZE-1]) && (diff[WSIZE-1] != a[WSIZE-1]);

   assign ror_w = {b, b} >> sh;
   assign rol_w = {b, b} << sh;

   always_comb begin
      res = '0;
      ovf = 1'b0;
      case (opcode)
         ALU_AND:  res = a & b;
         ALU_OR:   res = a | b;
         ALU_ADD:  begin res = sum;  ovf = add_ovf; end
         ALU_ADDU: res = sum;
         ALU_SUB:  begin res = diff; ovf = sub_ovf; end
         ALU_SUBU: res = diff;
         ALU_SLT:  res = {{(WSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: res = {{(WSIZE-1){1'b0}}, (a < b)};
         ALU_NOR:  res = ~(a | b);
         ALU_XOR:  res = a ^ b;
         ALU_SLL:  res = b << sh;
         ALU_SRL:  res = b >> sh;
         ALU_SRA:  res = $signed(b) >>> sh;
         ALU_ROR:  res = ror_w[WSIZE-1:0];
         ALU_ROL:  res = rol_w[2*WSIZE-1:WSIZE];
         default:  res = '0;
      endcase
   end

   assign r = ovf ? '0 : res;
   assign z = (r == '0);
   assign o = ovf;

endmodule

// File: rtl/mips_ula_arbiter.sv
// Round-robin arbiter sharing one MIPS_ULA between two valid/ready requesters.
// Define MIPS_ULA_ARB_STATS_EN to implement the saturating grant/overflow counters.
module mips_ula_arbiter
   import mips_ula_pkg::*;
#(
   parameter int WSIZE  = 32,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [3:0]        req0_opcode,
   input  logic [WSIZE-1:0]  req0_a,
   input  logic [WSIZE-1:0]  req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [3:0]        req1_opcode,
   input  logic [WSIZE-1:0]  req1_a,
   input  logic [WSIZE-1:0]  req1_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [WSIZE-1:0]  rsp_r,
   output logic              rsp_z,
   output logic              rsp_o,
   output logic [STAT_W-1:0] stat_grant0,
   output logic [STAT_W-1:0] stat_grant1,
   output logic [STAT_W-1:0] stat_ovf
);

   arb_state_t       state;
   arb_state_t       state_nx;
   logic             last_grant;
   logic             grant0;
   logic             grant1;
   logic [3:0]       op_q;
   logic [WSIZE-1:0] a_q;
   logic [WSIZE-1:0] b_q;
   logic             id_q;
   logic [WSIZE-1:0] alu_r;
   logic             alu_z;
   logic             alu_o;

   // Grants exist only in IDLE; on contention the requester not served last wins.
   always_comb begin
      state_nx   = state;
      grant0     = 1'b0;
      grant1     = 1'b0;
      case (state)
         IDLE: begin
            if (!rst) begin
               if (req0_valid && req1_valid) begin
                  grant0 = last_grant;
                  grant1 = !last_grant;
               end else begin
                  grant0 = req0_valid;
                  grant1 = req1_valid;
               end
            end
            if (grant0 || grant1) state_nx = EXEC;
         end
         EXEC:    state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp_valid  = (state == RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
      end else begin
         state <= state_nx;
         if (grant0 || grant1) begin
            op_q       <= grant1 ? req1_opcode : req0_opcode;
            a_q        <= grant1 ? req1_a      : req0_a;
            b_q        <= grant1 ? req1_b      : req0_b;
            id_q       <= grant1;
            last_grant <= grant1;
         end
      end
   end

   MIPS_ULA #(
      .WSIZE (WSIZE)
   ) u_alu (
      .opcode (op_q),
      .a      (a_q),
      .b      (b_q),
      .r      (alu_r),
      .z      (alu_z),
      .o      (alu_o)
   );

   // Response registers load only on leaving EXEC, so they hold through backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_id <= 1'b0;
         rsp_r  <= '0;
         rsp_z  <= 1'b0;
         rsp_o  <= 1'b0;
      end else if (state == EXEC) begin
         rsp_id <= id_q;
         rsp_r  <= alu_r;
         rsp_z  <= alu_z;
         rsp_o  <= alu_o;
      end
   end

`ifdef MIPS_ULA_ARB_STATS_EN
   localparam logic [STAT_W-1:0] SAT_MAX = '1;
   localparam logic [STAT_W-1:0] ONE     = {{(STAT_W-1){1'b0}}, 1'b1};

   logic [STAT_W-1:0] grant0_cnt;
   logic [STAT_W-1:0] grant1_cnt;
   logic [STAT_W-1:0] ovf_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant0_cnt <= '0;
         grant1_cnt <= '0;
         ovf_cnt    <= '0;
      end else begin
         if (grant0 && (grant0_cnt != SAT_MAX)) grant0_cnt <= grant0_cnt + ONE;
         if (grant1 && (grant1_cnt != SAT_MAX)) grant1_cnt <= grant1_cnt + ONE;
         if ((state == EXEC) && alu_o && (ovf_cnt != SAT_MAX)) ovf_cnt <= ovf_cnt + ONE;
      end
   end

   assign stat_grant0 = grant0_cnt;
   assign stat_grant1 = grant1_cnt;
   assign stat_ovf    = ovf_cnt;
`else
   assign stat_grant0 = '0;
   assign stat_grant1 = '0;
   assign stat_ovf    = '0;
`endif

endmodule

// File: tb/tb_mips_ula_arbiter.sv
// Self-checking bench for mips_ula_arbiter: directed scenarios, then random traffic
// checked every cycle against a transaction-level reference model.
module tb_mips_ula_arbiter;
   import mips_ula_pkg::*;

   localparam int WSIZE  = 32;
   localparam int STAT_W = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_opcode = '0, req1_opcode = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp_valid, rsp_id, rsp_z, rsp_o;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_r;
   logic [15:0] stat_grant0, stat_grant1, stat_ovf;

   mips_ula_arbiter #(.WSIZE(WSIZE), .STAT_W(STAT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_opcode (req0_opcode),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_opcode (req1_opcode),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_r       (rsp_r),
      .rsp_z       (rsp_z),
      .rsp_o       (rsp_o),
      .stat_grant0 (stat_grant0),
      .stat_grant1 (stat_grant1),
      .stat_ovf    (stat_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [31:0] r;
      logic        z;
      logic        o;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic        seen_id[$];
   logic [31:0] seen_r[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          grant_cnt[2];
   int          ovf_cnt;
   logic        rr_last;
   logic        acc0 = 1'b0, acc1 = 1'b0;

   // Reference ALU written from the opcode definitions with wide signed arithmetic.
   function automatic void refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic o);
      longint sa, sb, s;
      int     sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(a[4:0]);
      r  = '0;
      o  = 1'b0;
      case (op)
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_ADD:  begin s = sa + sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); r = s[31:0]; end
         ALU_ADDU: r = a + b;
         ALU_SUB:  begin s = sa - sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); r = s[31:0]; end
         ALU_SUBU: r = a - b;
         ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
         ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         ALU_NOR:  r = ~(a | b);
         ALU_XOR:  r = a ^ b;
         ALU_SLL:  r = b << sh;
         ALU_SRL:  r = b >> sh;
         ALU_SRA:  begin s = sb >>> sh; r = s[31:0]; end
         ALU_ROR:  for (int i = 0; i < 32; i++) r[i] = b[(i + sh) % 32];
         ALU_ROL:  for (int i = 0; i < 32; i++) r[(i + sh) % 32] = b[i];
         default:  r = '0;
      endcase
      if (o) r = '0;
      z = (r == 32'd0);
   endfunction

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic resetModel();
      exp_q.delete();
      rr_last      = 1'b1;
      grant_cnt[0] = 0;
      grant_cnt[1] = 0;
      ovf_cnt      = 0;
      acc0         = 1'b0;
      acc1         = 1'b0;
   endtask

   task automatic doReset();
      rst        = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      resetModel();
   endtask

   // One clock cycle: compare every output with the model at the falling edge, then advance.
   task automatic tick();
      logic        e0, e1, ev, z, o;
      logic [31:0] r;
      exp_t        t;
      @(negedge clk);
      e0 = 1'b0;
      e1 = 1'b0;
      if (exp_q.size() == 0) begin
         if (req0_valid && req1_valid) begin
            e0 = rr_last;
            e1 = !rr_last;
         end else begin
            e0 = req0_valid;
            e1 = req1_valid;
         end
      end
      checkOutput("req0_ready", 32'(req0_ready), 32'(e0));
      checkOutput("req1_ready", 32'(req1_ready), 32'(e1));
      ev = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      if (ev && (exp_q[0].due == cyc) && exp_q[0].o) ovf_cnt++;
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
         checkOutput("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
         checkOutput("rsp_r", rsp_r, exp_q[0].r);
         checkOutput("rsp_z", 32'(rsp_z), 32'(exp_q[0].z));
         checkOutput("rsp_o", 32'(rsp_o), 32'(exp_q[0].o));
      end
`ifdef MIPS_ULA_ARB_STATS_EN
      checkOutput("stat_grant0", 32'(stat_grant0), sat(grant_cnt[0]));
      checkOutput("stat_grant1", 32'(stat_grant1), sat(grant_cnt[1]));
      checkOutput("stat_ovf", 32'(stat_ovf), sat(ovf_cnt));
`else
      checkOutput("stat_grant0", 32'(stat_grant0), 0);
      checkOutput("stat_grant1", 32'(stat_grant1), 0);
      checkOutput("stat_ovf", 32'(stat_ovf), 0);
`endif
      if (ev && rsp_ready) begin
         seen_id.push_back(rsp_id);
         seen_r.push_back(rsp_r);
         void'(exp_q.pop_front());
      end
      acc0 = e0;
      acc1 = e1;
      if (e0 || e1) begin
         if (e1) refAlu(req1_opcode, req1_a, req1_b, r, z, o);
         else    refAlu(req0_opcode, req0_a, req0_b, r, z, o);
         t.id  = e1;
         t.r   = r;
         t.z   = z;
         t.o   = o;
         t.due = cyc + 2;
         exp_q.push_back(t);
         rr_last = e1;
         grant_cnt[e1 ? 1 : 0]++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Issue one request from a single requester, leaving the bench at the start of its response cycle.
   task automatic runSingle(input logic who, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      rsp_ready = 1'b1;
      if (who) begin
         req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
   endtask

   task automatic genReq(output logic [3:0] op, output logic [31:0] a, output logic [31:0] b);
      int sel;
      op  = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? $urandom_range(0, 40) : (sel == 1) ? 32'h7FFF_FFFF : $urandom();
      sel = $urandom_range(0, 3);
      b   = (sel == 0) ? $urandom_range(0, 40) : (sel == 1) ? 32'h8000_0000 : $urandom();
   endtask

   task automatic applyStimulus();
      if (acc0 || (req0_valid && ($urandom_range(0, 15) == 0))) req0_valid = 1'b0;
      if (!req0_valid && ($urandom_range(0, 2) == 0)) begin
         req0_valid = 1'b1;
         genReq(req0_opcode, req0_a, req0_b);
      end
      if (acc1 || (req1_valid && ($urandom_range(0, 15) == 0))) req1_valid = 1'b0;
      if (!req1_valid && ($urandom_range(0, 2) == 0)) begin
         req1_valid = 1'b1;
         genReq(req1_opcode, req1_a, req1_b);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      resetModel();
      doReset();
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("reset_rsp_id", 32'(rsp_id), 0);
      checkOutput("reset_rsp_r", rsp_r, 0);
      checkOutput("reset_rsp_z", 32'(rsp_z), 0);
      checkOutput("reset_rsp_o", 32'(rsp_o), 0);
      checkOutput("reset_stat_grant0", 32'(stat_grant0), 0);

      runSingle(1'b0, ALU_ADD, 32'd5, 32'd7);
      checkOutput("add_valid_c2", 32'(rsp_valid), 1);
      checkOutput("add_id", 32'(rsp_id), 0);
      checkOutput("add_r", rsp_r, 12);
      checkOutput("add_z", 32'(rsp_z), 0);
      checkOutput("add_o", 32'(rsp_o), 0);
      tick();
      checkOutput("add_valid_c3", 32'(rsp_valid), 0);

      doReset();
      seen_id.delete();
      seen_r.delete();
      rsp_ready  = 1'b1;
      req0_valid = 1'b1; req0_opcode = ALU_AND; req0_a = 32'hF0F0; req0_b = 32'h00FF;
      req1_valid = 1'b1; req1_opcode = ALU_SUB; req1_a = 32'd3;    req1_b = 32'd3;
      repeat (12) tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checkOutput("alt_count", 32'(seen_id.size()), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < seen_id.size()) begin
            checkOutput("alt_id", 32'(seen_id[i]), i % 2);
            checkOutput("alt_r", seen_r[i], (i % 2 == 0) ? 32'h00F0 : 32'h0);
         end
      end
      repeat (2) tick();

      doReset();
      runSingle(1'b1, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
      checkOutput("ovf_r", rsp_r, 0);
      checkOutput("ovf_z", 32'(rsp_z), 1);
      checkOutput("ovf_o", 32'(rsp_o), 1);
      checkOutput("ovf_id", 32'(rsp_id), 1);
`ifdef MIPS_ULA_ARB_STATS_EN
      checkOutput("ovf_stat", 32'(stat_ovf), 1);
`else
      checkOutput("ovf_stat", 32'(stat_ovf), 0);
`endif
      tick();

      rsp_ready  = 1'b0;
      req0_valid = 1'b1; req0_opcode = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
      tick();
      req0_a = 32'd10; req0_b = 32'd20;
      repeat (6) tick();
      checkOutput("bp_r_held", rsp_r, 3);
      rsp_ready = 1'b1;
      tick();
      checkOutput("bp_accept", 32'(req0_ready), 1);
      tick();
      req0_valid = 1'b0;
      repeat (3) tick();

      req1_valid = 1'b1; req1_opcode = ALU_SLTU; req1_a = 32'd1; req1_b = 32'd2;
      tick();
      req1_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_rsp_valid", 32'(rsp_valid), 0);
      checkOutput("arst_rsp_r", 32'(rsp_r), 0);
      resetModel();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) tick();
      req0_valid = 1'b1; req0_opcode = ALU_OR;  req0_a = 32'd1; req0_b = 32'd2;
      req1_valid = 1'b1; req1_opcode = ALU_XOR; req1_a = 32'd1; req1_b = 32'd3;
      #1;
      checkOutput("arst_first_grant0", 32'(req0_ready), 1);
      checkOutput("arst_first_grant1", 32'(req1_ready), 0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) tick();

      runSingle(1'b0, 4'b1111, 32'd3, 32'd4);
      checkOutput("unk_r", rsp_r, 0);
      checkOutput("unk_z", 32'(rsp_z), 1);
      checkOutput("unk_o", 32'(rsp_o), 0);
      tick();
      runSingle(1'b1, ALU_SRA, 32'd4, 32'h8000_0000);
      checkOutput("sra_r", rsp_r, 32'hF800_0000);
      tick();

      repeat (1500) begin
         applyStimulus();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
